// File: rtl/ex_lsu.sv
// Execute-stage load/store unit: data-memory req/gnt/rvalid handshake, byte-lane
// steering for stores, lane selection and extension for loads, pipeline stall and timeout.
module ex_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ex_mtype_i,
    input  logic        id_ex_mem_rw_i,
    input  logic [1:0]  id_ex_mem_width_i,
    input  logic [31:0] id_ex_mem_wr_data_i,
    input  logic        id_ex_mem_rdtype_i,
    input  logic [4:0]  id_ex_reg_waddr_i,
    input  logic [31:0] ex_addr_i,
    input  logic        fc_flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_load_valid_o,
    output logic [31:0] lsu_load_data_o,
    output logic [4:0]  lsu_load_waddr_o,
    output logic        lsu_misalign_o,
    output logic        lsu_bus_err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, rdtype_q, kill_q;
    logic [1:0]  width_q, off_q;
    logic [4:0]  waddr_q;
    logic [7:0]  cnt_q;
    logic        misalign_q, bus_err_q, load_valid_q;
    logic [31:0] load_data_q;
    logic [4:0]  load_waddr_q;

    logic        aligned, accept, misalign_det;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        stall, load_done, timeout;
    logic        expired;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Alignment check and lane steering for the instruction currently in EX
    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b0000;
        wdata_new = id_ex_mem_wr_data_i;
        case (id_ex_mem_width_i)
            2'd0: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << ex_addr_i[1:0];
                wdata_new = {4{id_ex_mem_wr_data_i[7:0]}};
            end
            2'd1: begin
                aligned   = ~ex_addr_i[0];
                be_new    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{id_ex_mem_wr_data_i[15:0]}};
            end
            2'd2: begin
                aligned   = (ex_addr_i[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = id_ex_mem_wr_data_i;
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    assign accept       = id_ex_mtype_i & ~fc_flush_i & aligned;
    assign misalign_det = id_ex_mtype_i & ~fc_flush_i & ~aligned;
    assign expired      = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        load_done = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = StIdle;
                    end else begin
                        stall   = 1'b1;
                        state_d = StWait;
                    end
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            StWait: begin
                if (dmem_rvalid_i) begin
                    load_done = 1'b1;
                    state_d   = StIdle;
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = dmem_rdata_i[7:0];
            2'd1:    rd_byte = dmem_rdata_i[15:8];
            2'd2:    rd_byte = dmem_rdata_i[23:16];
            default: rd_byte = dmem_rdata_i[31:24];
        endcase
        rd_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (width_q)
            2'd0:    rd_ext = rdtype_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = rdtype_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            rdtype_q     <= 1'b0;
            width_q      <= '0;
            off_q        <= '0;
            waddr_q      <= '0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            load_waddr_q <= '0;
        end else begin
            state_q      <= state_d;
            misalign_q   <= (state_q == StIdle) & misalign_det;
            bus_err_q    <= timeout;
            // A flush seen at any point of the transaction kills the writeback
            load_valid_q <= load_done & ~kill_q & ~fc_flush_i;
            if (load_done) begin
                load_data_q  <= rd_ext;
                load_waddr_q <= waddr_q;
            end
            if (state_q == StIdle) begin
                kill_q <= 1'b0;
            end else if (fc_flush_i) begin
                kill_q <= 1'b1;
            end
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != StIdle) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == StIdle && accept) begin
                addr_q   <= {ex_addr_i[31:2], 2'b00};
                wdata_q  <= wdata_new;
                be_q     <= be_new;
                we_q     <= id_ex_mem_rw_i;
                rdtype_q <= id_ex_mem_rdtype_i;
                width_q  <= id_ex_mem_width_i;
                off_q    <= ex_addr_i[1:0];
                waddr_q  <= id_ex_reg_waddr_i;
            end
        end
    end

    assign dmem_req_o       = (state_q == StReq);
    assign dmem_we_o        = dmem_req_o & we_q;
    assign dmem_addr_o      = dmem_req_o ? addr_q : 32'h0;
    assign dmem_be_o        = dmem_req_o ? be_q : 4'h0;
    assign dmem_wdata_o     = dmem_req_o ? wdata_q : 32'h0;
    assign lsu_stall_o      = stall;
    assign lsu_load_valid_o = load_valid_q;
    assign lsu_load_data_o  = load_data_q;
    assign lsu_load_waddr_o = load_waddr_q;
    assign lsu_misalign_o   = misalign_q;
    assign lsu_bus_err_o    = bus_err_q;

endmodule
